// File: rtl/uarttx_if.sv
// Producer-side handshake for uarttx: a byte on data is taken at an edge where req && ready.
interface uarttx_if;
    logic [7:0] data;
    logic       req;
    logic       ready;

    modport master (output data, output req, input ready);
    modport slave  (input data, input req, output ready);
endinterface

// File: rtl/uarttx.sv
// UART 8N1 transmitter with a one-word holding register for gapless back-to-back frames.
// Define UARTTX_PARITY_EN to insert an even-parity bit between data and stop.
module uarttx #(
    parameter int div = 234
) (
    input  logic     clk,
    input  logic     rst,
    uarttx_if.slave  bus,
    output logic     txd,
    output logic     busy,
    output logic     done
);
    localparam int CW = $clog2(div);

`ifdef UARTTX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    hold, hold_n;
    logic          full, full_n;
    logic          txd_q, txd_n;
    logic          done_q, done_n;
    logic          ready_q;
    logic          tick;
    logic          load;
`ifdef UARTTX_PARITY_EN
    logic          par, par_n;
`endif

    assign tick      = (cnt == CW'(div - 1));
    assign txd       = txd_q;
    assign done      = done_q;
    assign busy      = (state != IDLE) || full;
    assign bus.ready = ready_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        hold_n  = hold;
        full_n  = full;
        txd_n   = txd_q;
        done_n  = 1'b0;
        load    = 1'b0;
`ifdef UARTTX_PARITY_EN
        par_n   = par;
`endif
        if (state != IDLE)
            cnt_n = tick ? '0 : cnt + 1'b1;

        case (state)
            IDLE:  if (full) load = 1'b1;
            START: if (tick) begin
                state_n = DATA;
                idx_n   = 3'd0;
                txd_n   = shift[0];
            end
            DATA:  if (tick) begin
                if (idx == 3'd7) begin
`ifdef UARTTX_PARITY_EN
                    state_n = PARITY;
                    txd_n   = par;
`else
                    state_n = STOP;
                    txd_n   = 1'b1;
`endif
                end else begin
                    shift_n = {1'b0, shift[7:1]};
                    txd_n   = shift[1];
                    idx_n   = idx + 3'd1;
                end
            end
`ifdef UARTTX_PARITY_EN
            PARITY: if (tick) begin
                state_n = STOP;
                txd_n   = 1'b1;
            end
`endif
            STOP:  if (tick) begin
                done_n = 1'b1;
                // A waiting word starts its start bit at this same edge: no idle gap.
                if (full) begin
                    load = 1'b1;
                end else begin
                    state_n = IDLE;
                    txd_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            shift_n = hold;
            full_n  = 1'b0;
            state_n = START;
            txd_n   = 1'b0;
            cnt_n   = '0;
            idx_n   = 3'd0;
`ifdef UARTTX_PARITY_EN
            par_n   = ^hold;
`endif
        end

        // ready is low whenever full, so this never collides with a load.
        if (bus.req && ready_q) begin
            hold_n = bus.data;
            full_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= 3'd0;
            shift   <= 8'd0;
            hold    <= 8'd0;
            full    <= 1'b0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
`ifdef UARTTX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shift   <= shift_n;
            hold    <= hold_n;
            full    <= full_n;
            txd_q   <= txd_n;
            done_q  <= done_n;
            ready_q <= !full_n;
`ifdef UARTTX_PARITY_EN
            par     <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_uarttx.sv
// Directed + random bench for uarttx (div=4); expected waveforms come from a frame-level model.
module tb_uarttx;
    localparam int DIV = 4;
`ifdef UARTTX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * DIV;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic txd, busy, done;
    int   checks = 0;
    int   errors = 0;
    bit   junk_en = 1'b0;
    logic [7:0] to_send[$];

    uarttx_if u_if ();

    uarttx #(.div(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (u_if),
        .txd  (txd),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line waveform of one frame, one entry per clock, bit k lasting DIV clocks.
    function automatic logic [63:0] model_wave(input logic [7:0] b);
        logic [63:0] w;
        logic [10:0] bits;
        w = '0;
        bits = {2'b11, b, 1'b0};
`ifdef UARTTX_PARITY_EN
        bits[9] = ^b;
`endif
        for (int i = 0; i < FL; i++) w[i] = bits[i / DIV];
        return w;
    endfunction

    task automatic drive();
        if (to_send.size() > 0) begin
            u_if.req  = 1'b1;
            u_if.data = (junk_en && u_if.ready !== 1'b1) ? 8'($urandom) : to_send[0];
        end else begin
            u_if.req  = 1'b0;
            u_if.data = 8'($urandom);
        end
    endtask

    task automatic step();
        bit acc;
        acc = (u_if.req === 1'b1) && (u_if.ready === 1'b1);
        @(posedge clk);
        #1;
        if (acc && to_send.size() > 0) void'(to_send.pop_front());
        drive();
    endtask

    task automatic wait_start(input string tag, output int lat);
        lat = 0;
        while (txd !== 1'b0 && lat < 200) begin
            step();
            lat++;
        end
        if (txd !== 1'b0) chk({tag, " start_timeout"}, 64'(txd), 64'd0);
    endtask

    // Current sample is the first clock of the start bit.
    task automatic frame(input logic [7:0] b, input string tag);
        logic [63:0] obs;
        int dn;
        obs = '0;
        dn = 0;
        obs[0] = txd;
        for (int i = 1; i < FL; i++) begin
            step();
            obs[i] = txd;
            if (done !== 1'b0) dn++;
        end
        chk({tag, " wave"}, obs, model_wave(b));
        chk({tag, " done_in_frame"}, 64'(dn), 64'd0);
        step();
        chk({tag, " done_pulse"}, 64'(done), 64'd1);
    endtask

    initial begin
        int lat;
        int bad;
        logic [7:0] exp_q[$];

        // Reset hold with a word offered
        u_if.req  = 1'b1;
        u_if.data = 8'hA5;
        to_send.push_back(8'hA5);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst txd",   64'(txd),       64'd1);
            chk("rst ready", 64'(u_if.ready), 64'd0);
            chk("rst busy",  64'(busy),      64'd0);
            chk("rst done",  64'(done),      64'd0);
        end
        rst = 1'b1;
        step();
        chk("ready after rst", 64'(u_if.ready), 64'd1);
        chk("busy after rst",  64'(busy),       64'd0);

        // Single frame and first-bit latency
        wait_start("a5", lat);
        chk("a5 latency", 64'(lat), 64'd2);
        frame(8'hA5, "a5");
        chk("a5 busy_end",  64'(busy),       64'd0);
        chk("a5 ready_end", 64'(u_if.ready), 64'd1);
        chk("a5 txd_idle",  64'(txd),        64'd1);

        // Back-to-back with req held high
        to_send.push_back(8'h00);
        to_send.push_back(8'hFF);
        drive();
        wait_start("b2b", lat);
        frame(8'h00, "b2b0");
        chk("b2b gap", 64'(txd), 64'd0);
        frame(8'hFF, "b2b1");
        chk("b2b busy_end", 64'(busy), 64'd0);

        // Parity-relevant patterns
        to_send.push_back(8'h07);
        to_send.push_back(8'h03);
        drive();
        wait_start("par", lat);
        frame(8'h07, "p07");
        chk("p gap", 64'(txd), 64'd0);
        frame(8'h03, "p03");

        // Random bytes with junk on data while the holding register is full
        junk_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            to_send.push_back(r);
            exp_q.push_back(r);
        end
        drive();
        wait_start("rnd", lat);
        for (int i = 0; i < 16; i++) begin
            frame(exp_q.pop_front(), $sformatf("rnd%0d", i));
            if (i < 15) chk($sformatf("rnd%0d gap", i), 64'(txd), 64'd0);
        end
        chk("rnd all_taken", 64'(to_send.size()), 64'd0);
        chk("rnd busy_end",  64'(busy),           64'd0);
        junk_en = 1'b0;

        // Mid-frame reset during data bit 3, with a second word held
        to_send.push_back(8'h3C);
        to_send.push_back(8'h55);
        drive();
        wait_start("mrst", lat);
        for (int i = 1; i <= 4 * DIV + 1; i++) step();
        chk("mrst held_taken", 64'(to_send.size()), 64'd0);
        rst = 1'b0;
        step();
        chk("mrst txd",   64'(txd),  64'd1);
        chk("mrst busy",  64'(busy), 64'd0);
        bad = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            step();
            if (txd !== 1'b1 || u_if.ready !== 1'b0) bad++;
        end
        chk("mrst hold_line", 64'(bad), 64'd0);
        to_send.push_back(8'h81);
        drive();
        rst = 1'b1;
        step();
        chk("mrst busy_after", 64'(busy), 64'd0);
        wait_start("m81", lat);
        chk("m81 latency", 64'(lat), 64'd2);
        frame(8'h81, "m81");
        bad = 0;
        for (int i = 0; i < 2 * FL; i++) begin
            step();
            if (txd !== 1'b1) bad++;
        end
        chk("discarded_word_silent", 64'(bad), 64'd0);
        chk("final busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
